fft_rw_engine: RTL and testbench
================================

// Module: fft_rw_engine
// PURPOSE
//  In-place radix-2 DIT FFT read/write engine: address generation, complex operand memory and write-back alignment.
//  Sits between the butterfly datapath and storage. Issues one butterfly (A,B pair) read per cycle.
//  Writes the butterfly results back to the same addresses CLKCYCLES cycles later.
// PARAMETERS
//  DATA_WIDTH  3  bits per real/imag component
//  ADDR_WIDTH  3  log2(N); N=2^ADDR_WIDTH points, ADDR_WIDTH stages
//  CLKCYCLES   4  butterfly latency = write-back delay, >=1
// PORTS
//  Clock/reset: single clock clk; reset clr is synchronous and active-high.
//  clk            in   1           clock, all state on rising edge
//  clr            in   1           synchronous active-high reset
//  start          in   1           level-sampled in IDLE; begins full FFT pass
//  A_real_in/A_imag_in/B_real_in/B_imag_in  in  DATA_WIDTH  butterfly results for current read pair
//  A_real_out/A_imag_out/B_real_out/B_imag_out out DATA_WIDTH  async read data at addr_A_read/addr_B_read
//  addr_A_read, addr_B_read   out  ADDR_WIDTH  operand addresses
//  addr_Twiddle               out  ADDR_WIDTH  twiddle ROM index (upper bit 0)
//  addr_A_write, addr_B_write out  ADDR_WIDTH  write-back addresses
//  roW            out  1           0=read only, 1=write-back this cycle (write enable)
//  done           out  1           one-cycle pulse, pass complete
//  busy           out  1           high from first READ cycle until done cycle inclusive
// BEHAVIOUR
//  - clr: FSM->IDLE; roW, done, busy=0; all addresses 0; delay line cleared (valid=0). Memory contents kept.
//  - FSM states:
//    - IDLE -(start)-> READ, stage s=0, j=0.
//    - READ: N/2 cycles, j=0..N/2-1, then -> DRAIN.
//    - DRAIN: CLKCYCLES cycles, then -> READ with s+1, or -> DONE if s=ADDR_WIDTH-1.
//    - DONE: 1 cycle, done=1, then -> IDLE.
//  - READ addresses: A = j with a 0 bit inserted at bit s; B = A | (1<<s).
//    - Twiddle = (j & ((1<<s)-1)) << (ADDR_WIDTH-1-s).
//    - Outside READ: all three addresses hold 0.
//  - Memory: N words of {real,imag} per lane. Asynchronous read; synchronous write on rising edge when roW=1.
//    - A data goes to addr_A_write; B data goes to addr_B_write. These never collide.
//  - Delay line: CLKCYCLES register stages carry {valid, addrA, addrB, A_re, A_im, B_re, B_im}.
//    - valid = (state==READ).
//    - roW and the write addresses/data are the last-stage outputs.
//    - Cycle timing: a read issued in cycle t is written at the end of cycle t+CLKCYCLES.
//  - DRAIN guarantees the last write of stage s lands before the first read of stage s+1 (no RAW hazard).
//  - Pass length: ADDR_WIDTH*(N/2+CLKCYCLES) cycles, then DONE. Defaults give 24 cycles.
//  - start while busy: ignored. clr mid-pass: abort. Pending delayed writes are discarded (roW=0 from next cycle).
//  - Width: addresses wrap modulo N. No arithmetic on data (pass-through only).
// CONFIGURATION
//  FFT_LOAD_PORT_EN defined: adds load_en(1), load_addr(ADDR_WIDTH), load_real(DATA_WIDTH), load_imag(DATA_WIDTH).
//    - While IDLE, load_en=1 writes the word at load_addr on the clock edge.
//    - load_en is ignored when not IDLE.
//  Undefined: no load ports. Memory is written only by butterfly write-back.
// STRUCTURE
//  Package fft_rw_pkg: FSM state enum typedef (IDLE, READ, DRAIN, DONE); stage counter width function/constant; N/2 constant.
//  Sub-module rw_delay_line (params WIDTH, DEPTH): clr-able shift register, used once for the packed write bundle.
//  Memory array and FSM/address logic stay inline.
// TESTING (defaults 3/3/4, FFT_LOAD_PORT_EN defined)
//  1. Reset: clr=1 for 2 cycles mid-pass -> roW=0, done=0, busy=0, all addresses 0; a later start runs a clean pass.
//  2. Read-address sequence after start:
//     - stage0 (A,B)=(0,1)(2,3)(4,5)(6,7), tw 0,0,0,0
//     - stage1 (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2
//     - stage2 (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3
//     - 4 idle cycles between stages.
//  3. Write alignment: drive A_real_in=j+1 during read j.
//     - roW=1 exactly 4 cycles after each read.
//     - addr_A_write equals the read address 4 cycles earlier; memory then holds j+1.
//  4. Completion: first READ cycle c0.
//     - done=1 only at c0+24, single pulse.
//     - busy high c0..c0+24, low after.
//  5. start held high during a pass -> no restart.
//     - After done, start=1 -> new pass begins next cycle.
//  6. Load 8 words, run a pass with inputs driven from read outputs (identity butterfly) -> memory unchanged after done.

Source files
------------

// File: rtl/fft_rw_pkg.sv
// Shared definitions for the in-place radix-2 DIT FFT read/write engine.
//   state_t      : engine FSM states (IDLE, READ, DRAIN, DONE)
//   stage_width  : bits needed to count ADDR_WIDTH stages
//   cnt_width    : bits needed for the shared READ/DRAIN cycle counter
//   half_n       : butterflies per stage (N/2)
package fft_rw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int half_n(input int addr_w);
        return 1 << (addr_w - 1);
    endfunction

    function automatic int stage_width(input int addr_w);
        return (addr_w > 1) ? $clog2(addr_w) : 1;
    endfunction

    // One counter serves both the READ phase (N/2 cycles) and the DRAIN
    // phase (depth cycles), so it is sized for the longer of the two.
    function automatic int cnt_width(input int halfn, input int depth);
        int m;
        m = (halfn > depth) ? halfn : depth;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/fft_rw_engine_delay_line.sv
// rw_delay_line: clearable shift register used to align butterfly results
// with the addresses they were read from.
//   clk  : clock, rising edge
//   clr  : synchronous active-high clear of every stage
//   d    : bundle entering stage 0
//   q    : bundle leaving the last stage (DEPTH cycles after entry)
module rw_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] dly_p [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) dly_p[i] <= '0;
        end else begin
            dly_p[0] <= d;
            for (int i = 1; i < DEPTH; i++) dly_p[i] <= dly_p[i-1];
        end
    end

    assign q = dly_p[DEPTH-1];

endmodule

// File: rtl/fft_rw_engine.sv
// fft_rw_engine: in-place radix-2 DIT FFT read/write engine. Generates one
// butterfly operand pair per cycle, serves the operands from an internal
// complex memory and writes the butterfly results back to the same addresses
// CLKCYCLES cycles later.
//   clk, clr                     : clock / synchronous active-high reset
//   start                        : begins a full FFT pass when idle
//   A/B_{real,imag}_in           : butterfly results for the current pair
//   A/B_{real,imag}_out          : asynchronous read data at the read addresses
//   addr_A_read, addr_B_read     : operand addresses
//   addr_Twiddle                 : twiddle ROM index
//   addr_A_write, addr_B_write   : write-back addresses
//   roW                          : write-back enable this cycle
//   done                         : one-cycle pulse at end of pass
//   busy                         : high from first read cycle through done
// Optional feature macro FFT_LOAD_PORT_EN adds load_en/load_addr/load_real/
// load_imag for writing memory words while the engine is idle.
module fft_rw_engine
    import fft_rw_pkg::*;
#(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 3,
    parameter int CLKCYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
`ifdef FFT_LOAD_PORT_EN
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_real,
    input  logic [DATA_WIDTH-1:0] load_imag,
`endif
    input  logic [DATA_WIDTH-1:0] A_real_in,
    input  logic [DATA_WIDTH-1:0] A_imag_in,
    input  logic [DATA_WIDTH-1:0] B_real_in,
    input  logic [DATA_WIDTH-1:0] B_imag_in,
    output logic [DATA_WIDTH-1:0] A_real_out,
    output logic [DATA_WIDTH-1:0] A_imag_out,
    output logic [DATA_WIDTH-1:0] B_real_out,
    output logic [DATA_WIDTH-1:0] B_imag_out,
    output logic [ADDR_WIDTH-1:0] addr_A_read,
    output logic [ADDR_WIDTH-1:0] addr_B_read,
    output logic [ADDR_WIDTH-1:0] addr_Twiddle,
    output logic [ADDR_WIDTH-1:0] addr_A_write,
    output logic [ADDR_WIDTH-1:0] addr_B_write,
    output logic                  roW,
    output logic                  done,
    output logic                  busy
);

    localparam int N      = 1 << ADDR_WIDTH;
    localparam int HALF_N = half_n(ADDR_WIDTH);
    localparam int SW     = stage_width(ADDR_WIDTH);
    localparam int CW     = cnt_width(HALF_N, CLKCYCLES);
    localparam int BW     = 1 + 2*ADDR_WIDTH + 4*DATA_WIDTH;

    state_t        state, state_nx;
    logic [SW-1:0] stage, stage_nx;
    logic [CW-1:0] cnt, cnt_nx;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            stage <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            stage <= stage_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        stage_nx = stage;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = READ;
                    stage_nx = '0;
                    cnt_nx   = '0;
                end
            end
            READ: begin
                if (cnt == CW'(HALF_N - 1)) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            // DRAIN lets the last write of this stage land before the next
            // stage reads any of the same words.
            DRAIN: begin
                if (cnt == CW'(CLKCYCLES - 1)) begin
                    cnt_nx = '0;
                    if (stage == SW'(ADDR_WIDTH - 1)) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = READ;
                        stage_nx = stage + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign done = (state == DONE);
    assign busy = (state != IDLE);

    // A is the butterfly index j with a zero inserted at bit 'stage';
    // B is its partner with that bit set.
    logic [ADDR_WIDTH-1:0] j, mask, a_addr;

    always_comb begin
        j            = ADDR_WIDTH'(cnt);
        mask         = (ADDR_WIDTH'(1) << stage) - ADDR_WIDTH'(1);
        a_addr       = ((j & ~mask) << 1) | (j & mask);
        addr_A_read  = '0;
        addr_B_read  = '0;
        addr_Twiddle = '0;
        if (state == READ) begin
            addr_A_read  = a_addr;
            addr_B_read  = a_addr | (ADDR_WIDTH'(1) << stage);
            addr_Twiddle = (j & mask) << (ADDR_WIDTH - 1 - int'(stage));
        end
    end

    // Write-back alignment: read pair and its results travel together
    logic [BW-1:0]         wb_in, wb_out;
    logic [DATA_WIDTH-1:0] wa_re, wa_im, wb_re, wb_im;

    assign wb_in = {state == READ, addr_A_read, addr_B_read,
                    A_real_in, A_imag_in, B_real_in, B_imag_in};

    rw_delay_line #(
        .WIDTH (BW),
        .DEPTH (CLKCYCLES)
    ) u_wb_dly (
        .clk (clk),
        .clr (clr),
        .d   (wb_in),
        .q   (wb_out)
    );

    assign {roW, addr_A_write, addr_B_write, wa_re, wa_im, wb_re, wb_im} = wb_out;

    // Operand memory: contents survive clr
    logic [DATA_WIDTH-1:0] mem_re [N];
    logic [DATA_WIDTH-1:0] mem_im [N];

    always_ff @(posedge clk) begin
        if (roW) begin
            mem_re[addr_A_write] <= wa_re;
            mem_im[addr_A_write] <= wa_im;
            mem_re[addr_B_write] <= wb_re;
            mem_im[addr_B_write] <= wb_im;
        end
`ifdef FFT_LOAD_PORT_EN
        if (load_en && state == IDLE) begin
            mem_re[load_addr] <= load_real;
            mem_im[load_addr] <= load_imag;
        end
`endif
    end

    assign A_real_out = mem_re[addr_A_read];
    assign A_imag_out = mem_im[addr_A_read];
    assign B_real_out = mem_re[addr_B_read];
    assign B_imag_out = mem_im[addr_B_read];

endmodule

// File: tb/tb_fft_rw_engine.sv
// Directed bench for fft_rw_engine at DATA_WIDTH=3, ADDR_WIDTH=3, CLKCYCLES=4.
// Load-port stimulus is used when FFT_LOAD_PORT_EN is defined.
module tb_fft_rw_engine;

    localparam int DW = 3;
    localparam int AW = 3;
    localparam int NN = 8;

    logic          clk = 1'b0;
    logic          clr, start;
    logic [DW-1:0] a_re_in, a_im_in, b_re_in, b_im_in;
    logic [DW-1:0] a_re_out, a_im_out, b_re_out, b_im_out;
    logic [AW-1:0] addr_a_rd, addr_b_rd, addr_tw, addr_a_wr, addr_b_wr;
    logic          row, done, busy;
`ifdef FFT_LOAD_PORT_EN
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_real, load_imag;
`endif

    fft_rw_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLKCYCLES(4)) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
`ifdef FFT_LOAD_PORT_EN
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_real    (load_real),
        .load_imag    (load_imag),
`endif
        .A_real_in    (a_re_in),
        .A_imag_in    (a_im_in),
        .B_real_in    (b_re_in),
        .B_imag_in    (b_im_in),
        .A_real_out   (a_re_out),
        .A_imag_out   (a_im_out),
        .B_real_out   (b_re_out),
        .B_imag_out   (b_im_out),
        .addr_A_read  (addr_a_rd),
        .addr_B_read  (addr_b_rd),
        .addr_Twiddle (addr_tw),
        .addr_A_write (addr_a_wr),
        .addr_B_write (addr_b_wr),
        .roW          (row),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cur_k  = 0;

    // Hand-derived read sequence: stage 0, 1, 2 in order
    int exp_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int exp_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int exp_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    logic [DW-1:0] m_re [NN];
    logic [DW-1:0] m_im [NN];
    bit            known [NN];
    logic [DW-1:0] d_are [32];
    logic [DW-1:0] d_aim [32];
    logic [DW-1:0] d_bre [32];
    logic [DW-1:0] d_bim [32];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cur_k, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, " roW"},  row,  0);
        check_val({tag, " done"}, done, 0);
        check_val({tag, " busy"}, busy, 0);
        check_val({tag, " addrA"}, addr_a_rd, 0);
        check_val({tag, " addrB"}, addr_b_rd, 0);
        check_val({tag, " tw"},    addr_tw,   0);
        check_val({tag, " wrA"},   addr_a_wr, 0);
        check_val({tag, " wrB"},   addr_b_wr, 0);
    endtask

    // Entered at #1 inside an idle cycle. mode 0: patterned results,
    // mode 1: identity butterfly. hold keeps start high for the whole pass.
    // stop_k >= 0 returns early at that cycle offset (for abort testing).
    task automatic run_pass(input int mode, input bit hold, input int stop_k);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int k = 0; k <= 24; k++) begin
            int st, pos, idx, kr, wi;
            bit rd, wr;
            if (k == stop_k) return;
            cur_k = k;
            st  = k / 8;
            pos = k % 8;
            rd  = (k < 24) && (pos < 4);
            idx = st * 4 + pos;
            if (rd) begin
                check_val("rd addrA", addr_a_rd, exp_a[idx]);
                check_val("rd addrB", addr_b_rd, exp_b[idx]);
                check_val("rd tw",    addr_tw,   exp_tw[idx]);
                if (known[exp_a[idx]]) begin
                    check_val("rd A re", a_re_out, m_re[exp_a[idx]]);
                    check_val("rd A im", a_im_out, m_im[exp_a[idx]]);
                end
                if (known[exp_b[idx]]) begin
                    check_val("rd B re", b_re_out, m_re[exp_b[idx]]);
                    check_val("rd B im", b_im_out, m_im[exp_b[idx]]);
                end
            end else begin
                check_val("gap addrA", addr_a_rd, 0);
                check_val("gap addrB", addr_b_rd, 0);
                check_val("gap tw",    addr_tw,   0);
            end
            kr = k - 4;
            wr = (kr >= 0) && ((kr % 8) < 4) && (kr < 24);
            check_val("roW", row, wr);
            if (wr) begin
                wi = (kr / 8) * 4 + (kr % 8);
                check_val("wr addrA", addr_a_wr, exp_a[wi]);
                check_val("wr addrB", addr_b_wr, exp_b[wi]);
                m_re[exp_a[wi]] = d_are[kr];
                m_im[exp_a[wi]] = d_aim[kr];
                m_re[exp_b[wi]] = d_bre[kr];
                m_im[exp_b[wi]] = d_bim[kr];
                known[exp_a[wi]] = 1'b1;
                known[exp_b[wi]] = 1'b1;
            end
            check_val("done", done, k == 24);
            check_val("busy", busy, 1);
            if (mode == 0) begin
                a_re_in = DW'(pos + 1);
                a_im_in = DW'(st + 1);
                b_re_in = DW'(7 - pos);
                b_im_in = DW'(st + pos);
                d_are[k] = a_re_in;
                d_aim[k] = a_im_in;
                d_bre[k] = b_re_in;
                d_bim[k] = b_im_in;
            end else begin
                a_re_in = a_re_out;
                a_im_in = a_im_out;
                b_re_in = b_re_out;
                b_im_in = b_im_out;
                if (rd) begin
                    d_are[k] = m_re[exp_a[idx]];
                    d_aim[k] = m_im[exp_a[idx]];
                    d_bre[k] = m_re[exp_b[idx]];
                    d_bim[k] = m_im[exp_b[idx]];
                end
            end
`ifdef FFT_LOAD_PORT_EN
            // must be ignored while the pass is running
            load_en   = (mode == 1);
            load_addr = '0;
            load_real = 3'd5;
            load_imag = 3'd5;
`endif
            @(posedge clk); #1;
        end
`ifdef FFT_LOAD_PORT_EN
        load_en = 1'b0;
`endif
        cur_k = 25;
        check_idle("post-done");
    endtask

    initial begin
        clr = 1'b1; start = 1'b0;
        a_re_in = '0; a_im_in = '0; b_re_in = '0; b_im_in = '0;
`ifdef FFT_LOAD_PORT_EN
        load_en = 1'b0; load_addr = '0; load_real = '0; load_imag = '0;
`endif
        for (int i = 0; i < NN; i++) begin
            known[i] = 1'b0; m_re[i] = '0; m_im[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        clr = 1'b0;
        @(posedge clk); #1;

        // abort mid-pass while writes are still pending
        run_pass(0, 1'b0, 6);
        clr = 1'b1;
        @(posedge clk); #1;
        check_idle("abort1");
        @(posedge clk); #1;
        check_idle("abort2");
        clr = 1'b0;
        for (int i = 0; i < NN; i++) known[i] = 1'b0;
        @(posedge clk); #1;
        check_idle("after abort");

`ifdef FFT_LOAD_PORT_EN
        for (int i = 0; i < NN; i++) begin
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_real = DW'(i);
            load_imag = DW'(7 - i);
            m_re[i]   = DW'(i);
            m_im[i]   = DW'(7 - i);
            known[i]  = 1'b1;
            @(posedge clk); #1;
        end
        load_en = 1'b0;
`endif

        run_pass(0, 1'b0, -1);
        run_pass(0, 1'b1, -1);
        run_pass(1, 1'b0, -1);
        run_pass(1, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
